// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, the
// transfer-counter width and the round-robin search helper.
// Optional feature macro: UART_TX_ARB_LOCK_EN (frame lock, adds LOCK_* states).
package uart_pkg;

    // Width of the bytes-sent counter; it wraps silently at all-ones.
    localparam int TX_COUNT_WIDTH = 16;

    // The search helper works on a fixed maximum-sized vector so one function
    // serves every legal requester count (2..16).
    localparam int RR_MAX_REQ = 16;
    localparam int RR_MAX_IDX = 4;

    // Holding-register FSM. The lock states only exist when frame lock is built.
    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        FULL       = 2'd1
`ifdef UART_TX_ARB_LOCK_EN
        ,
        LOCK_EMPTY = 2'd2,
        LOCK_FULL  = 2'd3
`endif
    } arb_state_t;

    // Round-robin search: starting at last+1 and wrapping modulo num, return
    // {found, index} of the first set bit of mask. mask bits at or above num
    // are never examined. last must be below num, num must be 1..16.
    function automatic logic [RR_MAX_IDX:0] rr_next(
        input logic [RR_MAX_REQ-1:0] mask,
        input logic [RR_MAX_IDX-1:0] last,
        input logic [RR_MAX_IDX:0]   num
    );
        logic [RR_MAX_IDX:0] result;
        logic [RR_MAX_IDX:0] cand;
        result = '0;
        for (int s = 1; s <= RR_MAX_REQ; s++) begin
            cand = (RR_MAX_IDX+1)'(last) + (RR_MAX_IDX+1)'(s);
            if (cand >= num) begin
                cand = cand - num;
            end
            if ((s <= int'(num)) && !result[RR_MAX_IDX] && mask[cand[RR_MAX_IDX-1:0]]) begin
                result = {1'b1, cand[RR_MAX_IDX-1:0]};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker. The caller owns the last-grant pointer;
// this block only searches from last+1 and reports a one-hot grant and index.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int REQ_NUM   = 4,
    parameter int IDX_WIDTH = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_last,
    input  logic                 i_enable,
    output logic [REQ_NUM-1:0]   o_grant,
    output logic [IDX_WIDTH-1:0] o_idx
);

    localparam logic [RR_MAX_IDX:0] NUM_REQ = (RR_MAX_IDX+1)'(REQ_NUM);

    logic [RR_MAX_IDX:0] w_search;

    // Search result is {found, index}; the index is meaningful only when found.
    assign w_search = rr_next(RR_MAX_REQ'(i_req), RR_MAX_IDX'(i_last), NUM_REQ);
    assign o_idx    = IDX_WIDTH'(w_search[RR_MAX_IDX-1:0]);

    // A grant is only issued when the parent has room for a byte.
    assign o_grant  = (i_enable && w_search[RR_MAX_IDX])
                    ? (REQ_NUM'(1) << o_idx)
                    : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between REQ_NUM byte-stream requesters.
// A one-entry holding register feeds the transmitter; a new byte may be
// accepted in the same cycle the transmitter samples the current one, so
// consecutive frames chain without an idle gap.
// Optional feature macro: UART_TX_ARB_LOCK_EN (grant stays with one requester
// until it sends a byte marked last).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int REQ_NUM    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int IDX_WIDTH  = $clog2(REQ_NUM)
) (
    input  logic                          clk_i,
    input  logic                          s_rst_n_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data_i,
    input  logic [REQ_NUM-1:0]            req_last_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    output logic                          tx_enable_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_load_i,
    output logic [IDX_WIDTH-1:0]          grant_idx_o,
    output logic [TX_COUNT_WIDTH-1:0]     tx_count_o
);

    arb_state_t                r_state;
    arb_state_t                w_stateNext;
    logic [DATA_WIDTH-1:0]     r_txData;
    logic [IDX_WIDTH-1:0]      r_grantIdx;
    logic [IDX_WIDTH-1:0]      r_lastGrant;
    logic [TX_COUNT_WIDTH-1:0] r_txCount;

    logic                      w_holdFull;
    logic                      w_slotFree;
    logic                      w_accept;
    logic                      w_txDone;
    logic                      w_winLast;
    logic [REQ_NUM-1:0]        w_eligible;
    logic [REQ_NUM-1:0]        w_grant;
    logic [IDX_WIDTH-1:0]      w_winIdx;
    logic [DATA_WIDTH-1:0]     w_winData;

`ifdef UART_TX_ARB_LOCK_EN
    logic                      w_locked;

    // Decode the state into holding-register occupancy and lock status.
    always_comb begin
        w_holdFull = (r_state == FULL) || (r_state == LOCK_FULL);
        w_locked   = (r_state == LOCK_EMPTY) || (r_state == LOCK_FULL);
    end

    // While locked only the owner may compete. The owner is always the
    // requester of the most recently accepted byte, i.e. r_grantIdx.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_eligible[i] = req_valid_i[i] && (!w_locked || (r_grantIdx == IDX_WIDTH'(i)));
        end
    end

    // Last-of-frame flag of whichever requester wins this cycle.
    assign w_winLast = |(req_last_i & w_grant);
`else
    logic                      w_unusedLast;

    // Without frame lock the holding register is simply full or empty.
    always_comb begin
        w_holdFull = (r_state == FULL);
    end

    // Every valid requester competes on every byte; frame markers are ignored.
    assign w_eligible   = req_valid_i;
    assign w_winLast    = 1'b1;
    assign w_unusedLast = ^req_last_i;
`endif

    // There is room for a byte when the register is empty or is being
    // emptied by the transmitter this very cycle. Ready is held low in reset.
    assign w_slotFree = !w_holdFull || tx_load_i;
    assign w_accept   = |w_grant;
    assign w_txDone   = tx_load_i && w_holdFull;

    uart_rr_arbiter #(
        .REQ_NUM   (REQ_NUM),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rrArbiter (
        .i_req    (w_eligible),
        .i_last   (r_lastGrant),
        .i_enable (w_slotFree && s_rst_n_i),
        .o_grant  (w_grant),
        .o_idx    (w_winIdx)
    );

    // Steer the winning requester's byte towards the holding register.
    always_comb begin
        w_winData = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_grant[i]) begin
                w_winData = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: an accept always leaves the register full (locked
    // unless the byte closes its frame); a load without accept empties it.
    always_comb begin
        arb_state_t w_acceptState;
        w_acceptState = w_winLast ? FULL : arb_state_t'(2'd0);
`ifdef UART_TX_ARB_LOCK_EN
        w_acceptState = w_winLast ? FULL : LOCK_FULL;
`else
        w_acceptState = FULL;
`endif
        w_stateNext = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_stateNext = w_acceptState;
                end
            end
            FULL: begin
                if (w_accept) begin
                    w_stateNext = w_acceptState;
                end else if (tx_load_i) begin
                    w_stateNext = EMPTY;
                end
            end
`ifdef UART_TX_ARB_LOCK_EN
            LOCK_EMPTY: begin
                if (w_accept) begin
                    w_stateNext = w_acceptState;
                end
            end
            LOCK_FULL: begin
                if (w_accept) begin
                    w_stateNext = w_acceptState;
                end else if (tx_load_i) begin
                    w_stateNext = LOCK_EMPTY;
                end
            end
`endif
            default: begin
                w_stateNext = EMPTY;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge s_rst_n_i) begin
        if (!s_rst_n_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Holding register and round-robin pointer update only on accept, so a
    // drained register still shows the last byte and its source.
    always_ff @(posedge clk_i or negedge s_rst_n_i) begin
        if (!s_rst_n_i) begin
            r_txData    <= '0;
            r_grantIdx  <= '0;
            r_lastGrant <= IDX_WIDTH'(REQ_NUM - 1);
        end else if (w_accept) begin
            r_txData    <= w_winData;
            r_grantIdx  <= w_winIdx;
            r_lastGrant <= w_winIdx;
        end
    end

    // Count bytes actually sampled by the transmitter; loads on an empty
    // register carry no data and are not counted.
    always_ff @(posedge clk_i or negedge s_rst_n_i) begin
        if (!s_rst_n_i) begin
            r_txCount <= '0;
        end else if (w_txDone) begin
            r_txCount <= r_txCount + 1'b1;
        end
    end

    assign req_ready_o = w_grant;
    assign tx_enable_o = w_holdFull;
    assign tx_data_o   = r_txData;
    assign grant_idx_o = r_grantIdx;
    assign tx_count_o  = r_txCount;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with four requesters.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1ns after a rising edge. Frame-lock scenario runs only when
// UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rstN;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqLast;
    logic [3:0]  reqReady;
    logic        txEnable;
    logic [7:0]  txData;
    logic        txLoad;
    logic [1:0]  grantIdx;
    logic [15:0] txCount;

    int passCount  = 0;
    int checkCount = 0;

    uart_tx_arbiter #(
        .REQ_NUM    (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk_i       (clk),
        .s_rst_n_i   (rstN),
        .req_valid_i (reqValid),
        .req_data_i  (reqData),
        .req_last_i  (reqLast),
        .req_ready_o (reqReady),
        .tx_enable_o (txEnable),
        .tx_data_o   (txData),
        .tx_load_i   (txLoad),
        .grant_idx_o (grantIdx),
        .tx_count_o  (txCount)
    );

    // Free-running 100MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hold reset for two cycles with everything idle; returns on the falling
    // edge where reset is released.
    task automatic doReset();
        @(negedge clk);
        rstN     = 1'b0;
        reqValid = 4'b0000;
        reqData  = 32'h0;
        reqLast  = 4'b1111;
        txLoad   = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // Reset with all requesters asking, then the very first grant.
    task automatic test_reset();
        @(negedge clk);
        rstN     = 1'b0;
        reqValid = 4'b1111;
        reqData  = 32'hA3A2A1A0;
        reqLast  = 4'b1111;
        txLoad   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkCount++;
        if (reqReady !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", reqReady);
        else passCount++;
        checkCount++;
        if (txEnable !== 1'b0) $display("[TB] FAIL reset_enable: got %b expected 0", txEnable);
        else passCount++;
        checkCount++;
        if (txData !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", txData);
        else passCount++;
        checkCount++;
        if (grantIdx !== 2'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", grantIdx);
        else passCount++;
        checkCount++;
        if (txCount !== 16'h0000) $display("[TB] FAIL reset_count: got %h expected 0000", txCount);
        else passCount++;
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkCount++;
        if (reqReady !== 4'b0001) $display("[TB] FAIL first_ready: got %b expected 0001", reqReady);
        else passCount++;
        @(posedge clk);
        #1;
        checkCount++;
        if (txEnable !== 1'b1) $display("[TB] FAIL first_enable: got %b expected 1", txEnable);
        else passCount++;
        checkCount++;
        if (txData !== 8'hA0) $display("[TB] FAIL first_data: got %h expected a0", txData);
        else passCount++;
        checkCount++;
        if (reqReady !== 4'b0000) $display("[TB] FAIL full_ready: got %b expected 0000", reqReady);
        else passCount++;
    endtask

    // All four requesters valid, transmitter loads every 10 cycles.
    task automatic test_round_robin();
        logic [7:0] expBytes [5];
        logic [3:0] expReady;
        logic       enableHeld;
        expBytes   = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        enableHeld = 1'b1;
        doReset();
        reqValid = 4'b1111;
        reqData  = 32'hA3A2A1A0;
        for (int k = 0; k < 5; k++) begin
            repeat (9) begin
                @(negedge clk);
                if (txEnable !== 1'b1) enableHeld = 1'b0;
            end
            @(negedge clk);
            checkCount++;
            if (txData !== expBytes[k]) $display("[TB] FAIL rr_byte%0d: got %h expected %h", k, txData, expBytes[k]);
            else passCount++;
            txLoad = 1'b1;
            #1;
            expReady = 4'b0001 << ((k + 1) % 4);
            checkCount++;
            if (reqReady !== expReady) $display("[TB] FAIL rr_ready%0d: got %b expected %b", k, reqReady, expReady);
            else passCount++;
            @(negedge clk);
            txLoad = 1'b0;
            if (txEnable !== 1'b1) enableHeld = 1'b0;
        end
        checkCount++;
        if (enableHeld !== 1'b1) $display("[TB] FAIL rr_enable_held: got %b expected 1", enableHeld);
        else passCount++;
        checkCount++;
        if (txCount !== 16'd5) $display("[TB] FAIL rr_count: got %0d expected 5", txCount);
        else passCount++;
        reqValid = 4'b0000;
    endtask

    // A single byte from requester 2, then a stray load on an empty register.
    task automatic test_single();
        doReset();
        reqData  = 32'h00550000;
        reqValid = 4'b0100;
        #1;
        checkCount++;
        if (reqReady !== 4'b0100) $display("[TB] FAIL single_ready: got %b expected 0100", reqReady);
        else passCount++;
        checkCount++;
        if (txEnable !== 1'b0) $display("[TB] FAIL single_enable_pre: got %b expected 0", txEnable);
        else passCount++;
        @(negedge clk);
        reqValid = 4'b0000;
        checkCount++;
        if (txEnable !== 1'b1) $display("[TB] FAIL single_enable_rise: got %b expected 1", txEnable);
        else passCount++;
        checkCount++;
        if (txData !== 8'h55) $display("[TB] FAIL single_data: got %h expected 55", txData);
        else passCount++;
        checkCount++;
        if (grantIdx !== 2'd2) $display("[TB] FAIL single_idx: got %0d expected 2", grantIdx);
        else passCount++;
        repeat (3) @(negedge clk);
        checkCount++;
        if (txEnable !== 1'b1) $display("[TB] FAIL single_enable_hold: got %b expected 1", txEnable);
        else passCount++;
        txLoad = 1'b1;
        @(negedge clk);
        txLoad = 1'b0;
        checkCount++;
        if (txEnable !== 1'b0) $display("[TB] FAIL single_enable_fall: got %b expected 0", txEnable);
        else passCount++;
        checkCount++;
        if (txCount !== 16'd1) $display("[TB] FAIL single_count: got %0d expected 1", txCount);
        else passCount++;
        checkCount++;
        if (txData !== 8'h55 || grantIdx !== 2'd2) $display("[TB] FAIL single_keep: got %h/%0d expected 55/2", txData, grantIdx);
        else passCount++;
        txLoad = 1'b1;
        @(negedge clk);
        txLoad = 1'b0;
        checkCount++;
        if (txCount !== 16'd1) $display("[TB] FAIL stray_count: got %0d expected 1", txCount);
        else passCount++;
        checkCount++;
        if (txEnable !== 1'b0) $display("[TB] FAIL stray_enable: got %b expected 0", txEnable);
        else passCount++;
    endtask

    // Load and accept in the same cycle swap the held byte with no gap.
    task automatic test_back_to_back();
        doReset();
        reqData  = 32'h33001100;
        reqValid = 4'b0010;
        @(negedge clk);
        checkCount++;
        if (txData !== 8'h11 || txCount !== 16'd0) $display("[TB] FAIL b2b_first: got %h/%0d expected 11/0", txData, txCount);
        else passCount++;
        reqValid = 4'b1000;
        txLoad   = 1'b1;
        #1;
        checkCount++;
        if (reqReady !== 4'b1000) $display("[TB] FAIL b2b_ready: got %b expected 1000", reqReady);
        else passCount++;
        @(negedge clk);
        txLoad   = 1'b0;
        reqValid = 4'b0000;
        checkCount++;
        if (txData !== 8'h33) $display("[TB] FAIL b2b_data: got %h expected 33", txData);
        else passCount++;
        checkCount++;
        if (txEnable !== 1'b1) $display("[TB] FAIL b2b_enable: got %b expected 1", txEnable);
        else passCount++;
        checkCount++;
        if (grantIdx !== 2'd3) $display("[TB] FAIL b2b_idx: got %0d expected 3", grantIdx);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (txCount !== 16'd1 || txEnable !== 1'b1) $display("[TB] FAIL b2b_count: got %0d/%b expected 1/1", txCount, txEnable);
        else passCount++;
    endtask

    // Drive the counter to all-ones, let it wrap, then reset asynchronously
    // while a byte is held.
    task automatic test_count_wrap_reset();
        doReset();
        reqData  = 32'h000000C3;
        reqValid = 4'b0001;
        @(negedge clk);
        txLoad = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        txLoad = 1'b0;
        checkCount++;
        if (txCount !== 16'hFFFF) $display("[TB] FAIL count_max: got %h expected ffff", txCount);
        else passCount++;
        checkCount++;
        if (txEnable !== 1'b1) $display("[TB] FAIL count_enable: got %b expected 1", txEnable);
        else passCount++;
        txLoad = 1'b1;
        @(negedge clk);
        txLoad = 1'b0;
        checkCount++;
        if (txCount !== 16'h0000) $display("[TB] FAIL count_wrap: got %h expected 0000", txCount);
        else passCount++;
        txLoad = 1'b1;
        repeat (2) @(negedge clk);
        txLoad = 1'b0;
        checkCount++;
        if (txCount !== 16'd2 || txEnable !== 1'b1) $display("[TB] FAIL midrst_pre: got %h/%b expected 0002/1", txCount, txEnable);
        else passCount++;
        #2;
        rstN = 1'b0;
        #1;
        checkCount++;
        if (txEnable !== 1'b0) $display("[TB] FAIL midrst_enable: got %b expected 0", txEnable);
        else passCount++;
        checkCount++;
        if (txCount !== 16'h0000) $display("[TB] FAIL midrst_count: got %h expected 0000", txCount);
        else passCount++;
        checkCount++;
        if (txData !== 8'h00 || reqReady !== 4'b0000) $display("[TB] FAIL midrst_data: got %h/%b expected 00/0000", txData, reqReady);
        else passCount++;
        @(negedge clk);
        reqValid = 4'b0000;
        rstN     = 1'b1;
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    // Requester 1 sends a three-byte frame while requester 0 waits.
    task automatic test_frame_lock();
        doReset();
        reqLast  = 4'b0001;
        reqData  = 32'h0000B10A;
        reqValid = 4'b0010;
        @(negedge clk);
        checkCount++;
        if (txData !== 8'hB1) $display("[TB] FAIL lock_b1: got %h expected b1", txData);
        else passCount++;
        reqValid = 4'b0001;
        txLoad   = 1'b1;
        #1;
        checkCount++;
        if (reqReady !== 4'b0000) $display("[TB] FAIL lock_owner_idle: got %b expected 0000", reqReady);
        else passCount++;
        @(negedge clk);
        txLoad = 1'b0;
        checkCount++;
        if (txEnable !== 1'b0) $display("[TB] FAIL lock_drained: got %b expected 0", txEnable);
        else passCount++;
        reqData[15:8] = 8'hB2;
        reqValid      = 4'b0011;
        #1;
        checkCount++;
        if (reqReady !== 4'b0010) $display("[TB] FAIL lock_ready_b2: got %b expected 0010", reqReady);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (txData !== 8'hB2) $display("[TB] FAIL lock_b2: got %h expected b2", txData);
        else passCount++;
        reqData[15:8] = 8'hB3;
        reqLast       = 4'b0011;
        txLoad        = 1'b1;
        #1;
        checkCount++;
        if (reqReady !== 4'b0010) $display("[TB] FAIL lock_ready_b3: got %b expected 0010", reqReady);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if (txData !== 8'hB3) $display("[TB] FAIL lock_b3: got %h expected b3", txData);
        else passCount++;
        reqValid = 4'b0001;
        #1;
        checkCount++;
        if (reqReady !== 4'b0001) $display("[TB] FAIL unlock_ready: got %b expected 0001", reqReady);
        else passCount++;
        @(negedge clk);
        txLoad   = 1'b0;
        reqValid = 4'b0000;
        checkCount++;
        if (txData !== 8'h0A || grantIdx !== 2'd0) $display("[TB] FAIL unlock_r0: got %h/%0d expected 0a/0", txData, grantIdx);
        else passCount++;
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        rstN     = 1'b0;
        reqValid = 4'b0000;
        reqData  = 32'h0;
        reqLast  = 4'b1111;
        txLoad   = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_back_to_back();
`ifdef UART_TX_ARB_LOCK_EN
        test_frame_lock();
`endif
        test_count_wrap_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between REQ_NUM byte-stream requesters. Round-robin arbitration picks a requester, holds its byte in a one-entry holding register, and presents it to the transmitter's enable/data inputs until the transmitter signals that it has sampled the byte. It sits between client logic (console, debug, status reporters) and the transmitter, so the serialiser never sees more than one source.

## Interface
- REQ_NUM, 4: number of requesters; legal range 2..16.
- DATA_WIDTH, 8: byte width; must match the transmitter.
- IDX_WIDTH, $clog2(REQ_NUM): requester index width (derived, not overridden).
- clk_i  in  1  sole clock.
- s_rst_n_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  REQ_NUM  per-requester byte-valid.
- req_data_i  in  REQ_NUM*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  REQ_NUM  last byte of a frame; used only when UART_TX_ARB_LOCK_EN is defined.
- req_ready_o  out  REQ_NUM  one-hot accept; a byte transfers in any cycle where valid and ready are both high.
- tx_enable_o  out  1  drives the transmitter enable; high while the holding register is full.
- tx_data_o  out  DATA_WIDTH  holding-register byte.
- tx_load_i  in  1  one-cycle pulse from the transmitter when it samples tx_data_o (START-state baud tick).
- grant_idx_o  out  IDX_WIDTH  index of the requester whose byte is held.
- tx_count_o  out  16  count of bytes handed to the transmitter; wraps at 16'hFFFF to 0.

## Operation
- The holding register has a full flag, hold_full. tx_enable_o equals hold_full.
- Accept condition: acc = (!hold_full || tx_load_i) && |eligible. Here eligible is req_valid_i, masked to the lock owner when locked.
- req_ready_o = acc ? one-hot round-robin winner : 0. Ready is combinational from valid and registered state.
- Round-robin rule: search starts at index last_grant+1, wrapping modulo REQ_NUM. last_grant resets to REQ_NUM-1, so requester 0 wins first.
- On accept: the byte loads into tx_data_o, grant_idx_o and last_grant update to the winner, and hold_full is set.
- On tx_load_i with hold_full and no accept: hold_full clears, and tx_data_o and grant_idx_o keep their values.
- tx_load_i while hold_full=0 is ignored and is not counted.
- tx_count_o increments on each tx_load_i with hold_full=1.
- FSM states:
  - EMPTY: unlocked, no byte held. Goes to FULL on accept.
  - FULL: byte held, unlocked. On tx_load_i without accept, goes to EMPTY. On tx_load_i with accept, stays in FULL with the new byte.
  - LOCK_EMPTY and LOCK_FULL exist only with the macro. They are the same as EMPTY and FULL, except that only the owner is eligible.
- Reset mid-operation: all state clears immediately and asynchronously. A byte already latched inside the transmitter is its own concern; tx_enable_o drops at once.

## Timing
- Reset values: req_ready_o=0 (no state), tx_enable_o=0, tx_data_o=0, grant_idx_o=0, tx_count_o=0, FSM=EMPTY, last_grant=REQ_NUM-1.
- Latency: a byte accepted in cycle N appears on tx_data_o with tx_enable_o=1 in cycle N+1.
- Back-to-back transfers: tx_load_i and accept in the same cycle N keep tx_enable_o continuously high, with the new byte valid at N+1. The transmitter's STOP-state enable check then sees enable high and chains frames without an idle gap.
- Throughput: one byte per tx_load_i; arbitration adds no bubble.
- A requester may drop valid without a handshake; nothing is captured.

## Configuration
- UART_TX_ARB_LOCK_EN defined: frame lock is active.
  - An accepted byte with req_last_i=0 locks the grant to that requester (FSM goes to LOCK_*).
  - An accepted byte with req_last_i=1 from the owner unlocks, and round-robin resumes after the owner.
  - While locked, other requesters see ready=0 even if the owner is idle.
- Macro undefined: req_last_i is ignored, arbitration happens on every byte, and the LOCK_* states are not compiled.

## Structure
- Shared package uart_pkg holds:
  - the FSM state localparams EMPTY/FULL/LOCK_EMPTY/LOCK_FULL, 2-bit encoding;
  - the TX_COUNT_WIDTH=16 constant;
  - the rr_next(mask, last) function prototype width rules.
- One sub-module, uart_rr_arbiter, is natural. Its inputs are request vector, last index and enable; its outputs are one-hot grant and index. It is combinational, and its pointer is owned by the parent.
- Everything else stays in uart_tx_arbiter.

## Test plan
- Reset with all valids high: all outputs 0 during reset. Release, and on the first cycle req_ready_o=4'b0001; tx_data_o=req0 byte at +1.
- req_valid_i=4'b1111, bytes 8'hA0..8'hA3, tx_load_i pulsed every 10 cycles: transmitter receives A0, A1, A2, A3, A0 in order; tx_enable_o never drops.
- Single requester 2 sends 8'h55 and no more valid: tx_enable_o rises at +1 and falls the cycle after tx_load_i; tx_count_o=1; a later stray tx_load_i leaves the count at 1.
- tx_load_i and a new accept in the same cycle: tx_data_o switches directly to the new byte; tx_enable_o stays 1; count increments once.
- With UART_TX_ARB_LOCK_EN: requester 1 sends 3 bytes (last on the 3rd) while requester 0 is valid. Order is r1, r1, r1, then r0; req_ready_o[0]=0 throughout the lock.
- Assert s_rst_n_i low while FULL with tx_count_o=16'hFFFF: tx_enable_o=0 and count=0 immediately. A separate wrap run shows 16'hFFFF goes to 0 on the next load.
